// File: rtl/video_mem_arbiter.sv
// Single-port VRAM arbiter: scan-out (VID) has priority bounded by a starvation
// guard, CPU and blitter share round-robin; one transaction in flight at a time.
module video_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_vid_request,
    input  logic [31:0] i_vid_address,
    output logic [31:0] o_vid_rdata,
    output logic        o_vid_ready,
    input  logic        i_cpu_request,
    input  logic        i_cpu_rw,
    input  logic [31:0] i_cpu_address,
    input  logic [31:0] i_cpu_wdata,
    output logic [31:0] o_cpu_rdata,
    output logic        o_cpu_ready,
    input  logic        i_blt_request,
    input  logic        i_blt_rw,
    input  logic [31:0] i_blt_address,
    input  logic [31:0] i_blt_wdata,
    output logic [31:0] o_blt_rdata,
    output logic        o_blt_ready,
    output logic        o_mem_request,
    output logic        o_mem_rw,
    output logic [31:0] o_mem_address,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ready,
    output logic [1:0]  o_grant
);
    localparam int SW = $clog2(STARVE_LIMIT + 2);
    localparam logic [SW-1:0] STREAK_MAX = '1;
    localparam logic [SW-1:0] LIMIT      = SW'(STARVE_LIMIT);
    localparam logic [1:0] G_NONE = 2'd0, G_VID = 2'd1, G_CPU = 2'd2, G_BLT = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RELEASE} state_t;

    state_t        state_reg, state_next;
    logic [1:0]    grant_reg, grant_next;
    logic          mem_request_reg, mem_request_next;
    logic          mem_rw_reg, mem_rw_next;
    logic [31:0]   mem_address_reg, mem_address_next;
    logic [31:0]   mem_wdata_reg, mem_wdata_next;
    logic [31:0]   vid_rdata_reg, vid_rdata_next;
    logic [31:0]   cpu_rdata_reg, cpu_rdata_next;
    logic [31:0]   blt_rdata_reg, blt_rdata_next;
    logic          vid_ready_reg, vid_ready_next;
    logic          cpu_ready_reg, cpu_ready_next;
    logic          blt_ready_reg, blt_ready_next;
    logic          rr_blt_reg, rr_blt_next;
    logic [SW-1:0] streak_reg, streak_next;

    logic others_pending, starved, vid_wins, cpu_wins;

    assign others_pending = i_cpu_request | i_blt_request;
    assign starved  = (STARVE_LIMIT != 0) && (streak_reg == LIMIT) && others_pending;
    assign vid_wins = i_vid_request && !starved;
    // rr_blt_reg = 1 means the blitter wins the next CPU/BLT tie.
    assign cpu_wins = i_cpu_request && (!i_blt_request || !rr_blt_reg);

    always_comb begin
        state_next       = state_reg;
        grant_next       = grant_reg;
        mem_request_next = mem_request_reg;
        mem_rw_next      = mem_rw_reg;
        mem_address_next = mem_address_reg;
        mem_wdata_next   = mem_wdata_reg;
        vid_rdata_next   = vid_rdata_reg;
        cpu_rdata_next   = cpu_rdata_reg;
        blt_rdata_next   = blt_rdata_reg;
        vid_ready_next   = 1'b0;
        cpu_ready_next   = 1'b0;
        blt_ready_next   = 1'b0;
        rr_blt_next      = rr_blt_reg;
        streak_next      = streak_reg;
        case (state_reg)
            S_IDLE: begin
                grant_next = G_NONE;
                if (vid_wins) begin
                    grant_next       = G_VID;
                    mem_rw_next      = 1'b0;
                    mem_address_next = i_vid_address;
                    mem_wdata_next   = 32'd0;
                    mem_request_next = 1'b1;
                    state_next       = S_ACCESS;
                    if (!others_pending)
                        streak_next = '0;
                    else if (streak_reg != STREAK_MAX)
                        streak_next = streak_reg + SW'(1);
                end else if (others_pending) begin
                    if (cpu_wins) begin
                        grant_next       = G_CPU;
                        mem_rw_next      = i_cpu_rw;
                        mem_address_next = i_cpu_address;
                        mem_wdata_next   = i_cpu_wdata;
                        rr_blt_next      = 1'b1;
                    end else begin
                        grant_next       = G_BLT;
                        mem_rw_next      = i_blt_rw;
                        mem_address_next = i_blt_address;
                        mem_wdata_next   = i_blt_wdata;
                        rr_blt_next      = 1'b0;
                    end
                    mem_request_next = 1'b1;
                    streak_next      = '0;
                    state_next       = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (i_mem_ready) begin
                    mem_request_next = 1'b0;
                    state_next       = S_RELEASE;
                    case (grant_reg)
                        G_VID: begin
                            vid_rdata_next = i_mem_rdata;
                            vid_ready_next = 1'b1;
                        end
                        G_CPU: begin
                            if (!mem_rw_reg) cpu_rdata_next = i_mem_rdata;
                            cpu_ready_next = 1'b1;
                        end
                        G_BLT: begin
                            if (!mem_rw_reg) blt_rdata_next = i_mem_rdata;
                            blt_ready_next = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_RELEASE: begin
                grant_next = G_NONE;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_reg       <= S_IDLE;
            grant_reg       <= G_NONE;
            mem_request_reg <= 1'b0;
            mem_rw_reg      <= 1'b0;
            mem_address_reg <= 32'd0;
            mem_wdata_reg   <= 32'd0;
            vid_rdata_reg   <= 32'd0;
            cpu_rdata_reg   <= 32'd0;
            blt_rdata_reg   <= 32'd0;
            vid_ready_reg   <= 1'b0;
            cpu_ready_reg   <= 1'b0;
            blt_ready_reg   <= 1'b0;
            rr_blt_reg      <= 1'b0;
            streak_reg      <= '0;
        end else begin
            state_reg       <= state_next;
            grant_reg       <= grant_next;
            mem_request_reg <= mem_request_next;
            mem_rw_reg      <= mem_rw_next;
            mem_address_reg <= mem_address_next;
            mem_wdata_reg   <= mem_wdata_next;
            vid_rdata_reg   <= vid_rdata_next;
            cpu_rdata_reg   <= cpu_rdata_next;
            blt_rdata_reg   <= blt_rdata_next;
            vid_ready_reg   <= vid_ready_next;
            cpu_ready_reg   <= cpu_ready_next;
            blt_ready_reg   <= blt_ready_next;
            rr_blt_reg      <= rr_blt_next;
            streak_reg      <= streak_next;
        end
    end

    assign o_grant       = grant_reg;
    assign o_mem_request = mem_request_reg;
    assign o_mem_rw      = mem_rw_reg;
    assign o_mem_address = mem_address_reg;
    assign o_mem_wdata   = mem_wdata_reg;
    assign o_vid_rdata   = vid_rdata_reg;
    assign o_cpu_rdata   = cpu_rdata_reg;
    assign o_blt_rdata   = blt_rdata_reg;
    assign o_vid_ready   = vid_ready_reg;
    assign o_cpu_ready   = cpu_ready_reg;
    assign o_blt_ready   = blt_ready_reg;
endmodule

// File: tb/tb_video_mem_arbiter.sv
// Bench for video_mem_arbiter: transaction-timing model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_video_mem_arbiter;
    localparam int LIMIT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic        req[3];
    logic        rw[3];
    logic [31:0] addr[3];
    logic [31:0] wdata[3];
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] vid_rdata, cpu_rdata, blt_rdata;
    logic        vid_ready, cpu_ready, blt_ready;
    logic        mem_request, mem_rw;
    logic [31:0] mem_address, mem_wdata;
    logic [1:0]  grant;
    logic        rdy[3];
    logic [31:0] rdat[3];

    assign rdy[0] = vid_ready;
    assign rdy[1] = cpu_ready;
    assign rdy[2] = blt_ready;
    assign rdat[0] = vid_rdata;
    assign rdat[1] = cpu_rdata;
    assign rdat[2] = blt_rdata;

    video_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .i_clock(clk), .i_reset(rst),
        .i_vid_request(req[0]), .i_vid_address(addr[0]),
        .o_vid_rdata(vid_rdata), .o_vid_ready(vid_ready),
        .i_cpu_request(req[1]), .i_cpu_rw(rw[1]), .i_cpu_address(addr[1]),
        .i_cpu_wdata(wdata[1]), .o_cpu_rdata(cpu_rdata), .o_cpu_ready(cpu_ready),
        .i_blt_request(req[2]), .i_blt_rw(rw[2]), .i_blt_address(addr[2]),
        .i_blt_wdata(wdata[2]), .o_blt_rdata(blt_rdata), .o_blt_ready(blt_ready),
        .o_mem_request(mem_request), .o_mem_rw(mem_rw), .o_mem_address(mem_address),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .i_mem_ready(mem_ready),
        .o_grant(grant)
    );

    initial forever #5 clk = ~clk;

    // Stimulus knobs (written only by the main sequence)
    int          rate[3]   = '{0, 0, 0};
    int          budget[3] = '{-1, -1, -1};
    bit          fix_en = 0, fix_rdata_en = 0, spurious_en = 0, abandon_en = 0;
    logic [31:0] fix_addr[3]  = '{0, 0, 0};
    logic [31:0] fix_wdata[3] = '{0, 0, 0};
    logic        fix_rw[3]    = '{0, 0, 0};
    logic [31:0] fix_rdata = 0;
    int          lat_min = 0, lat_max = 2;
    bit          check_en = 0;

    int total = 0;
    int bad = 0;
    int glog[$];
    string pn[3] = '{"vid", "cpu", "blt"};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] any_out();
        return {31'd0, |{grant, mem_request, mem_rw, mem_address, mem_wdata,
                         vid_rdata, cpu_rdata, blt_rdata, vid_ready, cpu_ready, blt_ready}};
    endfunction

    // Requesters: hold until ready, drop the cycle after, optionally abandon mid-access
    initial begin
        bit wait_idle[3];
        int raised[3];
        for (int p = 0; p < 3; p++) begin
            req[p] = 0; rw[p] = 0; addr[p] = 0; wdata[p] = 0; wait_idle[p] = 0; raised[p] = 0;
        end
        forever begin
            @(negedge clk);
            for (int p = 0; p < 3; p++) begin
                if (rst) begin
                    req[p] = 0; wait_idle[p] = 0; raised[p] = 0;
                end else if (req[p]) begin
                    if (rdy[p]) req[p] = 0;
                    else if (abandon_en && grant == 2'(p + 1) && mem_request
                             && $urandom_range(15) == 0) begin
                        req[p] = 0; wait_idle[p] = 1;
                    end
                end else if (wait_idle[p]) begin
                    if (grant == 2'd0) wait_idle[p] = 0;
                end else if ((budget[p] < 0 || raised[p] < budget[p])
                             && $urandom_range(99) < rate[p]) begin
                    req[p] = 1;
                    raised[p]++;
                    if (fix_en) begin
                        addr[p] = fix_addr[p]; wdata[p] = fix_wdata[p]; rw[p] = fix_rw[p];
                    end else begin
                        addr[p] = $urandom; wdata[p] = $urandom; rw[p] = 1'($urandom_range(1));
                    end
                    if (p == 0) rw[p] = 0;
                end
            end
        end
    end

    // VRAM responder with random latency and occasional stray ready pulses
    initial begin
        int cnt;
        cnt = -1; mem_ready = 0; mem_rdata = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mem_ready = 0; cnt = -1;
            end else if (mem_ready) begin
                mem_ready = 0; cnt = -1;
            end else if (mem_request) begin
                if (cnt < 0) cnt = int'($urandom_range(lat_max, lat_min));
                if (cnt == 0) begin
                    mem_ready = 1;
                    mem_rdata = fix_rdata_en ? fix_rdata : $urandom;
                end else cnt--;
            end else if (spurious_en && $urandom_range(7) == 0) begin
                mem_ready = 1; mem_rdata = $urandom;
            end
        end
    end

    // Reference model: one transaction record; outputs follow from its grant edge g
    // and completion edge d (ready after d, grant drops after d+1, next pick at d+2).
    int          rr, streak, cyc;
    bit          m_active, m_rw;
    int          m_owner, m_g, m_d;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rdata[3];
    int          e_grant;
    bit          e_mreq;
    bit          e_rdy[3];

    function automatic int pick(bit v, bit c, bit b, int rr_i, int streak_i);
        if (v && !(LIMIT != 0 && streak_i == LIMIT && (c || b))) return 0;
        if (c && b) return (rr_i == 1) ? 2 : 1;
        if (c) return 1;
        if (b) return 2;
        return -1;
    endfunction

    initial begin
        int w;
        cyc = 0; m_active = 0; rr = 0; streak = 0; m_owner = 0; m_g = 0; m_d = -1;
        m_rw = 0; m_addr = 0; m_wdata = 0; m_rdata = '{0, 0, 0};
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_active = 0; rr = 0; streak = 0; m_rdata = '{0, 0, 0};
            end else if (m_active && m_d < 0 && mem_ready) begin
                m_d = cyc;
                if (!m_rw) m_rdata[m_owner] = mem_rdata;
            end else if (!m_active || (m_d >= 0 && cyc >= m_d + 2)) begin
                m_active = 0;
                w = pick(req[0], req[1], req[2], rr, streak);
                if (w >= 0) begin
                    m_active = 1; m_owner = w; m_g = cyc; m_d = -1;
                    m_addr = addr[w]; m_wdata = wdata[w]; m_rw = (w == 0) ? 1'b0 : rw[w];
                    if (w == 0) streak = (req[1] || req[2]) ? streak + 1 : 0;
                    else begin
                        streak = 0;
                        rr = (w == 1) ? 1 : 0;
                    end
                end
            end
            e_grant = (m_active && (m_d < 0 || cyc <= m_d)) ? m_owner + 1 : 0;
            e_mreq  = m_active && m_d < 0;
            for (int p = 0; p < 3; p++) e_rdy[p] = m_active && m_d == cyc && m_owner == p;
        end
    end

    // Per-cycle compare against the model, plus a log of observed grants
    initial begin
        logic [1:0] prev_g;
        prev_g = 0;
        forever begin
            @(negedge clk);
            if (check_en) begin
                chk("grant", grant, e_grant);
                chk("mem_request", mem_request, e_mreq);
                for (int p = 0; p < 3; p++) begin
                    chk({pn[p], "_ready"}, rdy[p], e_rdy[p]);
                    chk({pn[p], "_rdata"}, rdat[p], m_rdata[p]);
                end
                if (e_mreq) begin
                    chk("mem_address", mem_address, m_addr);
                    chk("mem_rw", mem_rw, m_rw);
                    if (m_rw) chk("mem_wdata", mem_wdata, m_wdata);
                end
            end
            if (grant != 2'd0 && grant != prev_g) glog.push_back(int'(grant));
            prev_g = grant;
        end
    end

    function automatic bit sel(int which);
        if (which == 3) return mem_request;
        return rdy[which];
    endfunction

    task automatic wait_sig(input int which, input int limit, input string name);
        int n = 0;
        while (1) begin
            @(negedge clk);
            if (sel(which)) break;
            n++;
            if (n >= limit) begin
                total++; bad++;
                $display("FAIL %s timeout actual=no_event expected=event", name);
                break;
            end
        end
    endtask

    task automatic wait_glog(input int target, input int limit, input string name);
        int n = 0;
        while (glog.size() < target) begin
            @(negedge clk);
            n++;
            if (n >= limit) begin
                total++; bad++;
                $display("FAIL %s timeout actual=%0d expected=%0d grants", name, glog.size(), target);
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1;
        for (int p = 0; p < 3; p++) begin rate[p] = 0; budget[p] = -1; end
        fix_en = 0; fix_rdata_en = 0; spurious_en = 0; abandon_en = 0;
        lat_min = 0; lat_max = 2;
        @(posedge clk);
        check_en = 1;
        @(negedge clk);
        chk("reset_state", any_out(), 0);
        @(posedge clk); #1;
        rst = 0;
    endtask

    initial begin
        int base;
        int exp_seq[4] = '{2, 3, 2, 3};

        // 1: CPU write
        do_reset();
        fix_en = 1; fix_addr[1] = 32'h100; fix_wdata[1] = 32'hDEADBEEF; fix_rw[1] = 1;
        budget[1] = 1; rate[1] = 100; lat_min = 2; lat_max = 2;
        wait_sig(3, 50, "t1_mreq");
        chk("t1_grant", grant, 2);
        chk("t1_rw", mem_rw, 1);
        chk("t1_addr", mem_address, 32'h100);
        chk("t1_wdata", mem_wdata, 32'hDEADBEEF);
        wait_sig(1, 50, "t1_ready");
        chk("t1_mreq_low", mem_request, 0);
        @(negedge clk);
        chk("t1_ready_one_pulse", cpu_ready, 0);
        chk("t1_grant_released", grant, 0);

        // 2: VID and CPU together
        do_reset();
        rate[0] = 100; rate[1] = 100; budget[0] = 1; budget[1] = 1; lat_min = 1; lat_max = 1;
        wait_sig(0, 50, "t2_vid_ready");
        chk("t2_first_grant", grant, 1);
        @(negedge clk);
        chk("t2_gap", grant, 0);
        @(negedge clk);
        chk("t2_second_grant", grant, 2);

        // 3: CPU and BLT continuous
        do_reset();
        base = glog.size();
        rate[1] = 100; rate[2] = 100;
        wait_glog(base + 4, 200, "t3_grants");
        for (int i = 0; i < 4; i++)
            chk($sformatf("t3_grant%0d", i), (glog.size() > base + i) ? glog[base + i] : -1, exp_seq[i]);

        // 4: starvation guard
        do_reset();
        base = glog.size();
        rate[0] = 100; rate[1] = 100; lat_min = 1; lat_max = 1;
        wait_glog(base + 18, 1000, "t4_grants");
        for (int i = 0; i < 18; i++)
            chk($sformatf("t4_grant%0d", i), (glog.size() > base + i) ? glog[base + i] : -1,
                (i == 8 || i == 17) ? 2 : 1);

        // 5: VID read data, CPU rdata untouched
        do_reset();
        fix_en = 1; fix_rw[1] = 0; fix_addr[1] = 32'h40; fix_addr[0] = 32'h80;
        fix_rdata_en = 1; fix_rdata = 32'hA5A5A5A5; lat_min = 1; lat_max = 1;
        rate[1] = 100; budget[1] = 1;
        wait_sig(1, 50, "t5_cpu_ready");
        chk("t5_cpu_rdata", cpu_rdata, 32'hA5A5A5A5);
        @(posedge clk); #1;
        fix_rdata = 32'h12345678; rate[0] = 100; budget[0] = 1;
        wait_sig(0, 50, "t5_vid_ready");
        chk("t5_vid_rdata", vid_rdata, 32'h12345678);
        chk("t5_cpu_rdata_kept", cpu_rdata, 32'hA5A5A5A5);

        // 6: reset in the middle of an access
        do_reset();
        rate[1] = 100; budget[1] = 1; lat_min = 6; lat_max = 6;
        wait_sig(3, 50, "t6_mreq");
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_all_zero", any_out(), 0);
        @(posedge clk); #1;
        rst = 0; rate[1] = 100; rate[2] = 100; budget[1] = -1; lat_min = 0; lat_max = 2;
        base = glog.size();
        wait_glog(base + 2, 100, "t6_grants");
        chk("t6_first_cpu", (glog.size() > base) ? glog[base] : -1, 2);
        chk("t6_then_blt", (glog.size() > base + 1) ? glog[base + 1] : -1, 3);

        // Randomized traffic
        do_reset();
        base = glog.size();
        for (int s = 0; s < 6; s++) begin
            @(posedge clk); #1;
            for (int p = 0; p < 3; p++) rate[p] = int'($urandom_range(100, 10));
            lat_min = 0; lat_max = int'($urandom_range(4)); spurious_en = 1; abandon_en = 1;
            if (s == 3) begin
                rst = 1;
                @(posedge clk); #1;
                rst = 0;
            end
            repeat (600) @(posedge clk);
        end
        chk("random_activity", (glog.size() - base > 100) ? 1 : 0, 1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
